// File: rtl/mc_cpu_core.sv
// Multi-cycle LA32R integer core: one instruction at a time walks IF/ID/EXE/MEM/WB
// over req/rvalid handshaked instruction and data memories, with a stall watchdog.
module mc_cpu_core #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          WAIT_W   = 8,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic [31:0]      inst_rdata,
  input  logic             inst_rvalid,
  output logic             data_req,
  output logic             data_we,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  input  logic [31:0]      data_rdata,
  input  logic             data_rvalid,
  output logic             halt_err,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_we,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata
);

  // Handshake: a req stays high until the matching rvalid is seen in the same
  // cycle; rvalid while req is low carries no meaning and is ignored.
  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EXE  = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  // Reaching this count on a further unacknowledged cycle means 2^WAIT_W-1 stalls.
  localparam logic [WAIT_W-1:0] WD_LAST = {{(WAIT_W-1){1'b1}}, 1'b0};

  logic [2:0]        state;
  logic [31:0]       pc, ir, opa, opb, target, alu_res, ld_data;
  logic              taken;
  logic [WAIT_W-1:0] wd_cnt;
  logic [31:0]       rf [0:31];

  logic [4:0]  rd, rj, rk, src2_reg, dest;
  logic [31:0] si12, ui5, si20, off16, off26;
  logic        is_add, is_sub, is_slt, is_sltu, is_nor, is_and, is_or, is_xor;
  logic        is_slli, is_srli, is_srai, is_addi, is_ld, is_st;
  logic        is_jirl, is_b, is_bl, is_beq, is_bne, is_lu12i;
  logic        gr_we, rf_we, rs_eq;
  logic [31:0] rd1, rd2, src1, src2, alu_out, wb_wdata;

  assign rd = ir[4:0];
  assign rj = ir[9:5];
  assign rk = ir[14:10];

  assign is_add   = ir[31:15] == 17'h00020;
  assign is_sub   = ir[31:15] == 17'h00022;
  assign is_slt   = ir[31:15] == 17'h00024;
  assign is_sltu  = ir[31:15] == 17'h00025;
  assign is_nor   = ir[31:15] == 17'h00028;
  assign is_and   = ir[31:15] == 17'h00029;
  assign is_or    = ir[31:15] == 17'h0002a;
  assign is_xor   = ir[31:15] == 17'h0002b;
  assign is_slli  = ir[31:15] == 17'h00081;
  assign is_srli  = ir[31:15] == 17'h00089;
  assign is_srai  = ir[31:15] == 17'h00091;
  assign is_addi  = ir[31:22] == 10'h00a;
  assign is_ld    = ir[31:22] == 10'h0a2;
  assign is_st    = ir[31:22] == 10'h0a6;
  assign is_jirl  = ir[31:26] == 6'h13;
  assign is_b     = ir[31:26] == 6'h14;
  assign is_bl    = ir[31:26] == 6'h15;
  assign is_beq   = ir[31:26] == 6'h16;
  assign is_bne   = ir[31:26] == 6'h17;
  assign is_lu12i = ir[31:25] == 7'h0a;

  assign si12  = {{20{ir[21]}}, ir[21:10]};
  assign ui5   = {27'd0, ir[14:10]};
  assign si20  = {ir[24:5], 12'd0};
  assign off16 = {{14{ir[25]}}, ir[25:10], 2'b00};
  assign off26 = {{4{ir[9]}}, ir[9:0], ir[25:10], 2'b00};

  // Stores and compare-branches read rd as their second register source.
  assign src2_reg = (is_st | is_beq | is_bne) ? rd : rk;
  assign rd1      = (rj == 5'd0) ? 32'd0 : rf[rj];
  assign rd2      = (src2_reg == 5'd0) ? 32'd0 : rf[src2_reg];
  assign rs_eq    = rd1 == rd2;

  // Undecoded words fall through with no write, behaving as a NOP.
  assign gr_we = is_add | is_sub | is_slt | is_sltu | is_nor | is_and | is_or |
                 is_xor | is_slli | is_srli | is_srai | is_addi | is_ld |
                 is_jirl | is_bl | is_lu12i;
  assign dest  = is_bl ? 5'd1 : rd;
  assign rf_we = (state == S_WB) & gr_we & (dest != 5'd0) & ~reset;

  // Link instructions reuse the adder to form PC+4.
  assign src1 = (is_bl | is_jirl) ? pc : opa;
  always_comb begin
    src2 = opb;
    if (is_bl | is_jirl)              src2 = 32'd4;
    else if (is_addi | is_ld | is_st) src2 = si12;
    else if (is_slli | is_srli | is_srai) src2 = ui5;
    else if (is_lu12i)                src2 = si20;
  end

  always_comb begin
    alu_out = 32'd0;
    if (is_add | is_addi | is_ld | is_st | is_bl | is_jirl) alu_out = src1 + src2;
    else if (is_sub)   alu_out = src1 - src2;
    else if (is_slt)   alu_out = {31'd0, $signed(src1) < $signed(src2)};
    else if (is_sltu)  alu_out = {31'd0, src1 < src2};
    else if (is_nor)   alu_out = ~(src1 | src2);
    else if (is_and)   alu_out = src1 & src2;
    else if (is_or)    alu_out = src1 | src2;
    else if (is_xor)   alu_out = src1 ^ src2;
    else if (is_slli)  alu_out = src1 << src2[4:0];
    else if (is_srli)  alu_out = src1 >> src2[4:0];
    else if (is_srai)  alu_out = $signed(src1) >>> src2[4:0];
    else if (is_lu12i) alu_out = src2;
  end

  assign wb_wdata = is_ld ? ld_data : alu_res;

  assign inst_req   = (state == S_IF) & ~reset;
  assign inst_addr  = pc;
  assign data_req   = (state == S_MEM) & ~reset;
  assign data_we    = data_req & is_st;
  assign data_addr  = alu_res;
  assign data_wdata = opb;

  assign debug_wb_pc       = pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = dest;
  assign debug_wb_rf_wdata = wb_wdata;

  always_ff @(posedge clk) begin
    if (rf_we) rf[dest] <= wb_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IF;
      pc          <= RESET_PC;
      ir          <= 32'd0;
      opa         <= 32'd0;
      opb         <= 32'd0;
      taken       <= 1'b0;
      target      <= 32'd0;
      alu_res     <= 32'd0;
      ld_data     <= 32'd0;
      wd_cnt      <= '0;
      halt_err    <= 1'b0;
      retired_cnt <= '0;
    end else begin
      case (state)
        S_IF: begin
          if (inst_rvalid) begin
            ir     <= inst_rdata;
            state  <= S_ID;
            wd_cnt <= '0;
          end else if (wd_cnt == WD_LAST) begin
            state    <= S_HALT;
            halt_err <= 1'b1;
            wd_cnt   <= '0;
          end else begin
            wd_cnt <= wd_cnt + WAIT_W'(1);
          end
        end
        S_ID: begin
          opa    <= rd1;
          opb    <= rd2;
          taken  <= is_b | is_bl | is_jirl | (is_beq & rs_eq) | (is_bne & ~rs_eq);
          target <= is_jirl ? rd1 + off16 : pc + ((is_b | is_bl) ? off26 : off16);
          state  <= S_EXE;
        end
        S_EXE: begin
          alu_res <= alu_out;
          state   <= (is_ld | is_st) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (data_rvalid) begin
            if (is_ld) ld_data <= data_rdata;
            state  <= S_WB;
            wd_cnt <= '0;
          end else if (wd_cnt == WD_LAST) begin
            state    <= S_HALT;
            halt_err <= 1'b1;
            wd_cnt   <= '0;
          end else begin
            wd_cnt <= wd_cnt + WAIT_W'(1);
          end
        end
        S_WB: begin
          pc          <= taken ? target : pc + 32'd4;
          retired_cnt <= retired_cnt + CNT_W'(1);
          state       <= S_IF;
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed bench for mc_cpu_core: a memory responder, a scoreboard monitor that
// pops expected fetch/data/write-back events, and a phase sequencer.
module tb_mc_cpu_core;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int WB_W = 77;  // {pc, wnum, wdata, latency}
  localparam int DQ_W = 73;  // {we, addr, wdata, held cycles}

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req, data_req, data_we, halt_err;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [31:0] inst_rdata = 32'd0;
  logic        inst_rvalid = 1'b0;
  logic [31:0] data_rdata = 32'd0;
  logic        data_rvalid = 1'b0;
  logic [31:0] retired_cnt, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;

  always #5 clk = ~clk;

  mc_cpu_core #(.RESET_PC(RESET_PC), .WAIT_W(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_rvalid(data_rvalid),
    .halt_err(halt_err), .retired_cnt(retired_cnt),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [WB_W-1:0] exp_q[$];
  logic [31:0]     exp_fetch_q[$];
  logic [DQ_W-1:0] exp_data_q[$];
  logic [31:0]     prog [0:31];

  logic [31:0] fetch_limit;
  int          data_wait;
  bit          inst_tie = 1'b0, inst_stray = 1'b0, data_stray = 1'b0;
  int          icnt = 0, dcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic report;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic exp_wb(input logic [31:0] pc, input logic [4:0] wnum,
                        input logic [31:0] wdata, input logic [7:0] lat);
    exp_q.push_back({pc, wnum, wdata, lat});
  endtask

  function automatic logic [31:0] imem(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - RESET_PC;
    if (off < 32'd128) return prog[off[6:2]];
    return 32'hffffffff;
  endfunction

  // Memory responder: decides rvalid/rdata for the coming clock edge.
  initial begin
    forever begin
      @(negedge clk);
      inst_rdata = imem(inst_addr);
      if (inst_req) begin
        inst_rvalid = (inst_addr < fetch_limit) || inst_stray;
        icnt++;
      end else begin
        inst_rvalid = inst_tie || inst_stray;
        icnt = 0;
      end
      if (data_req) begin
        if (data_wait >= 0 && dcnt >= data_wait) begin
          data_rvalid = 1'b1;
          data_rdata  = (data_addr == 32'h108) ? 32'hdeadbeef : 32'd0;
          dcnt = 0;
        end else begin
          data_rvalid = 1'b0;
          dcnt++;
        end
      end else begin
        data_rvalid = data_stray;
        data_rdata  = 32'h5a5a5a5a;
        dcnt = 0;
      end
    end
  end

  // Monitor: pops expected events whenever the DUT presents one.
  initial begin
    int cyc = 0, fetch_cyc = 0, dheld = 0;
    logic [31:0] daddr0 = 32'd0;
    logic [WB_W-1:0] e;
    logic [DQ_W-1:0] d;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!reset) begin
        if (inst_req && inst_rvalid) begin
          if (exp_fetch_q.size() == 0) fail_now("fetch_unexpected");
          else check("fetch_addr", inst_addr, exp_fetch_q.pop_front());
          fetch_cyc = cyc;
        end
        if (data_req) begin
          if (dheld == 0) daddr0 = data_addr;
          dheld++;
          if (data_rvalid) begin
            if (exp_data_q.size() == 0) fail_now("data_unexpected");
            else begin
              d = exp_data_q.pop_front();
              check("data_we", {31'd0, data_we}, {31'd0, d[72]});
              check("data_addr", data_addr, d[71:40]);
              check("data_addr_first", daddr0, d[71:40]);
              if (d[72]) check("data_wdata", data_wdata, d[39:8]);
              check("data_held", dheld, {24'd0, d[7:0]});
            end
            dheld = 0;
          end
        end else begin
          dheld = 0;
        end
        if (debug_wb_rf_we != 4'd0) begin
          if (exp_q.size() == 0) begin
            fail_now("wb_unexpected");
            $display("  pc %h wnum %0d wdata %h", debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata);
          end else begin
            e = exp_q.pop_front();
            check("wb_we", {28'd0, debug_wb_rf_we}, 32'hf);
            check("wb_pc", debug_wb_pc, e[76:45]);
            check("wb_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, e[44:40]});
            check("wb_wdata", debug_wb_rf_wdata, e[39:8]);
            check("wb_latency", cyc - fetch_cyc, {24'd0, e[7:0]});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    fail_now("global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  // Sequencer
  initial begin
    bit found;
    for (int i = 0; i < 32; i++) prog[i] = 32'h02800405;  // addi r5,r0,1: must never run
    prog[0]  = 32'h02801401;  // addi.w r1,r0,5
    prog[1]  = 32'h02840002;  // addi.w r2,r0,0x100
    prog[2]  = 32'h28802043;  // ld.w   r3,r2,8
    prog[3]  = 32'h29804043;  // st.w   r3,r2,0x10
    prog[4]  = 32'h00100c24;  // add.w  r4,r1,r3
    prog[5]  = 32'h58000800;  // beq    r0,r0,+8
    prog[7]  = 32'h5c000821;  // bne    r1,r1,+8
    prog[8]  = 32'h142468a6;  // lu12i.w r6,0x12345
    prog[9]  = 32'h00111027;  // sub.w  r7,r1,r4
    prog[10] = 32'h00489068;  // srai.w r8,r3,4
    prog[11] = 32'h00120469;  // slt    r9,r3,r1
    prog[12] = 32'h0012846a;  // sltu   r10,r3,r1
    prog[13] = 32'h54000800;  // bl     +8
    prog[15] = 32'h4c00082b;  // jirl   r11,r1,+8
    prog[16] = 32'hffffffff;  // undefined -> NOP

    // Phase 1: rvalid tied high, 3 wait states on data, program runs up to 0x44.
    inst_tie    = 1'b1;
    fetch_limit = RESET_PC + 32'h44;
    data_wait   = 3;
    foreach (prog[i]) if (i <= 16 && i != 6 && i != 14) exp_fetch_q.push_back(RESET_PC + 32'(i * 4));
    exp_wb(RESET_PC + 32'h00, 5'd1,  32'h00000005, 8'd3);
    exp_wb(RESET_PC + 32'h04, 5'd2,  32'h00000100, 8'd3);
    exp_wb(RESET_PC + 32'h08, 5'd3,  32'hdeadbeef, 8'd7);
    exp_wb(RESET_PC + 32'h10, 5'd4,  32'hdeadbef4, 8'd3);
    exp_wb(RESET_PC + 32'h20, 5'd6,  32'h12345000, 8'd3);
    exp_wb(RESET_PC + 32'h24, 5'd7,  32'h21524111, 8'd3);
    exp_wb(RESET_PC + 32'h28, 5'd8,  32'hfdeadbee, 8'd3);
    exp_wb(RESET_PC + 32'h2c, 5'd9,  32'h00000001, 8'd3);
    exp_wb(RESET_PC + 32'h30, 5'd10, 32'h00000000, 8'd3);
    exp_wb(RESET_PC + 32'h34, 5'd1,  RESET_PC + 32'h38, 8'd3);
    exp_wb(RESET_PC + 32'h3c, 5'd11, RESET_PC + 32'h40, 8'd3);
    exp_data_q.push_back({1'b0, 32'h108, 32'h0, 8'd4});
    exp_data_q.push_back({1'b1, 32'h110, 32'hdeadbeef, 8'd4});

    repeat (3) @(negedge clk);
    #3;
    check("rst_inst_req", {31'd0, inst_req}, 32'd0);
    check("rst_data_req", {31'd0, data_req}, 32'd0);
    check("rst_data_we", {31'd0, data_we}, 32'd0);
    check("rst_dbg_we", {28'd0, debug_wb_rf_we}, 32'd0);
    check("rst_halt_err", {31'd0, halt_err}, 32'd0);
    check("rst_retired", retired_cnt, 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    #2;
    check("first_inst_req", {31'd0, inst_req}, 32'd1);
    check("first_inst_addr", inst_addr, RESET_PC);

    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      #3;
      if (inst_req && inst_addr == RESET_PC + 32'h44) found = 1'b1;
    end
    if (!found) begin
      fail_now("reach_0x44_timeout");
      report();
    end
    check("retired_after_prog", retired_cnt, 32'd15);

    // Phase 2: fetch of 0x44 is never acknowledged -> watchdog.
    repeat (254) @(negedge clk);
    #3;
    check("wd_edge_inst_req", {31'd0, inst_req}, 32'd1);
    check("wd_edge_halt_err", {31'd0, halt_err}, 32'd0);
    @(negedge clk);
    #3;
    check("halt_err_set", {31'd0, halt_err}, 32'd1);
    check("halt_inst_req", {31'd0, inst_req}, 32'd0);
    #1 inst_stray = 1'b1;
    repeat (3) @(negedge clk);
    #1 inst_stray = 1'b0;
    @(negedge clk);
    #3;
    check("halt_sticky", {31'd0, halt_err}, 32'd1);
    check("halt_req_stays_0", {31'd0, inst_req}, 32'd0);
    check("halt_pc_frozen", inst_addr, RESET_PC + 32'h44);
    check("halt_retired", retired_cnt, 32'd15);
    check("phase1_wb_left", exp_q.size(), 32'd0);
    check("phase1_fetch_left", exp_fetch_q.size(), 32'd0);
    check("phase1_data_left", exp_data_q.size(), 32'd0);

    @(negedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    check("reset_clears_halt", {31'd0, halt_err}, 32'd0);
    check("reset_clears_retired", retired_cnt, 32'd0);
    check("reset_inst_req", {31'd0, inst_req}, 32'd0);

    // Phase 3: reset while a load waits in MEM.
    inst_tie    = 1'b0;
    fetch_limit = RESET_PC + 32'h0c;
    data_wait   = -1;
    exp_fetch_q.push_back(RESET_PC);
    exp_fetch_q.push_back(RESET_PC + 32'h04);
    exp_fetch_q.push_back(RESET_PC + 32'h08);
    exp_wb(RESET_PC + 32'h00, 5'd1, 32'h00000005, 8'd3);
    exp_wb(RESET_PC + 32'h04, 5'd2, 32'h00000100, 8'd3);
    @(negedge clk);
    #1 reset = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      #3;
      if (data_req) found = 1'b1;
    end
    if (!found) begin
      fail_now("reach_mem_timeout");
      report();
    end
    check("mem_wait_addr", data_addr, 32'h108);
    check("mem_wait_we", {31'd0, data_we}, 32'd0);
    repeat (2) @(negedge clk);
    #3;
    check("mem_wait_held", {31'd0, data_req}, 32'd1);
    check("retired_before_abort", retired_cnt, 32'd2);
    #1 reset = 1'b1;
    data_stray = 1'b1;
    @(negedge clk);
    #3;
    check("abort_data_req", {31'd0, data_req}, 32'd0);
    check("abort_dbg_we", {28'd0, debug_wb_rf_we}, 32'd0);
    fetch_limit = RESET_PC;
    @(negedge clk);
    #1 reset = 1'b0;
    #2;
    check("restart_inst_req", {31'd0, inst_req}, 32'd1);
    check("restart_inst_addr", inst_addr, RESET_PC);
    check("restart_retired", retired_cnt, 32'd0);
    repeat (6) @(negedge clk);
    #3;
    data_stray = 1'b0;
    check("late_rvalid_no_effect_req", {31'd0, inst_req}, 32'd1);
    check("late_rvalid_no_effect_addr", inst_addr, RESET_PC);
    check("late_rvalid_retired", retired_cnt, 32'd0);
    check("final_wb_left", exp_q.size(), 32'd0);
    check("final_fetch_left", exp_fetch_q.size(), 32'd0);
    report();
  end

endmodule

// File: doc/mc_cpu_core.md
Name: mc_cpu_core

Overview:
- Multi-cycle LA32R integer core: one instruction walks IF/ID/EXE/MEM/WB states; only one is in flight.
- Generalises the single-cycle core from fixed zero-latency SRAM ports to req/rvalid handshaked memories with arbitrary wait states.
- Adds configurable reset PC, a memory-timeout watchdog and a retired-instruction counter.
- Reuses the existing regfile, alu and decoder_* blocks; sits between the SoC memory wrappers and the trace-compare debug interface.

Parameters:
- RESET_PC, 32'h1c000000, address of the first fetch after reset.
- WAIT_W, 8, watchdog counter width; the timeout limit is 2^WAIT_W-1 unacknowledged cycles.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst_req  out  1  fetch request; held until inst_rvalid
- inst_addr  out  32  fetch address (PC); stable while inst_req
- inst_rdata  in  32  fetched word; valid when inst_rvalid
- inst_rvalid  in  1  fetch acknowledge/data valid
- data_req  out  1  load/store request; held until data_rvalid
- data_we  out  1  1=store, 0=load; stable while data_req
- data_addr  out  32  effective address
- data_wdata  out  32  store data (rd value)
- data_rdata  in  32  load data; valid when data_rvalid
- data_rvalid  in  1  load data valid / store accepted
- halt_err  out  1  sticky: watchdog expired
- retired_cnt  out  CNT_W  instructions completed through WB
- debug_wb_pc  out  32  PC of the instruction in WB
- debug_wb_rf_we  out  4  {4{rf write this cycle}}
- debug_wb_rf_wnum  out  5  destination register
- debug_wb_rf_wdata  out  32  write data

Behaviour:
- Reset: state=IF, PC=RESET_PC, IR=0, halt_err=0, retired_cnt=0. All req/we/debug_we outputs are 0 during reset; the cycle after reset deasserts, inst_req=1 with inst_addr=RESET_PC. Reset mid-transaction aborts it; any late rvalid is ignored.
- IF: inst_req=1. On inst_rvalid, latch IR←inst_rdata and go to ID. Zero-wait is allowed: rvalid in the same cycle as req. rvalid while req=0 is ignored.
- ID: decode IR with the same 20-instruction set: add.w, sub.w, slt, sltu, nor, and, or, xor, slli.w, srli.w, srai.w, addi.w, ld.w, st.w, jirl, b, bl, beq, bne, lu12i.w.
  - Immediate/source/dest rules are unchanged.
  - Register operands are latched into A/B.
  - Branch decision and target are computed and latched.
  - Next state is EXE.
- EXE: the ALU result is latched. ld.w/st.w go to MEM; all others go to WB.
- MEM: data_req=1 with data_we=st.w, data_addr=ALU result, data_wdata=B. On data_rvalid, latch the load data (loads only) and go to WB.
- WB, lasting exactly 1 cycle:
  - rf_we = gr_we & (dest!=0). gr_we=0 for st.w, b, beq, bne.
  - wdata = the load data for ld.w, else the ALU result. bl/jirl write PC+4 (r1 for bl).
  - PC←taken ? target : PC+4.
  - retired_cnt increments, wrapping at 2^CNT_W.
  - Next state is IF.
- Debug outputs are valid only in WB: debug_wb_rf_we={4{rf_we}}, wnum=dest, wdata=the write data. debug_wb_rf_we=0 in all other states.
- Undefined opcode: executes as a NOP (IF→ID→EXE→WB) with no write; PC+4; it is counted as retired.
- Minimum latency per instruction: 4 cycles for non-memory instructions, 5 for loads/stores, plus wait cycles.
- Watchdog: counts consecutive cycles with inst_req or data_req high and no rvalid; it is cleared on every acknowledge and on every state change.
  - When it reaches 2^WAIT_W-1, the core enters HALT: halt_err=1, all reqs=0, PC frozen.
  - HALT is left only by reset.
- Arithmetic is 32-bit modulo. Shift amount is imm[4:0]. jirl target = rj + (sext(i16)<<2); other branch targets = PC + offset.

Test Plan:
- Reset, then inst_rvalid tied 1 → inst_addr=0x1c000000 on the first post-reset cycle; inst_req=1.
- Fetch 0x02801401 (addi.w r1,r0,5) with zero wait → exactly 1 WB cycle, 4 cycles after fetch issue; debug_wb_rf_wnum=1, wdata=5; next inst_addr=0x1c000004; retired_cnt=1.
- ld.w with data_rvalid delayed 3 cycles, memory word 0xdeadbeef → data_req held 4 cycles with a stable address; the destination is written with 0xdeadbeef; PC+4.
- beq r0,r0,+8 → no rf write (debug_wb_rf_we=0); next inst_addr=PC+8. bne with equal operands → PC+4.
- Withhold inst_rvalid for 255 cycles with WAIT_W=8 → halt_err=1 and inst_req=0 from the next cycle; a subsequent rvalid has no effect; reset clears both.
- Assert reset during a MEM wait, then return rvalid → no rf write; fetch restarts at RESET_PC; retired_cnt=0.
